// File: rtl/psc_trigger_pkg.sv
// Shared constants and types for the PSC trigger link (transmit and receive sides).
package psc_trigger_pkg;

  localparam logic [7:0] SOP = 8'h3C;
  localparam logic [7:0] EOP = 8'hBC;

  localparam logic [3:0] IDX_SOP    = 4'd0;
  localparam logic [3:0] IDX_STATUS = 4'd1;
  localparam logic [3:0] IDX_CRC    = 4'd8;
  localparam logic [3:0] IDX_EOP    = 4'd9;
  localparam int         PKT_LEN    = 10;

  localparam logic [7:0] CRC_POLY_DEFAULT = 8'h07;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEND,
    ST_GAP
  } state_e;

endpackage

// File: rtl/psc_trigger_packet_tx_if.sv
// Byte stream toward the 8b10b encoder: data, K-flag and valid/ready handshake.
interface psc_trigger_packet_tx_if;

  logic [7:0] tx_data;
  logic       tx_k;
  logic       tx_valid;
  logic       tx_ready;

  modport master (
    output tx_data,
    output tx_k,
    output tx_valid,
    input  tx_ready
  );

  modport slave (
    input  tx_data,
    input  tx_k,
    input  tx_valid,
    output tx_ready
  );

endinterface

// File: rtl/psc_crc8.sv
// One-byte CRC8 step, MSB-first, no reflection, no final XOR.
module psc_crc8
  import psc_trigger_pkg::*;
#(
  parameter logic [7:0] CRC_POLY = CRC_POLY_DEFAULT
) (
  input  logic [7:0] crc_in,
  input  logic [7:0] data_in,
  output logic [7:0] crc_out
);

  logic [7:0] c;

  always_comb begin
    c = crc_in ^ data_in;
    for (int i = 0; i < 8; i++) begin
      c = c[7] ? ((c << 1) ^ CRC_POLY) : (c << 1);
    end
    crc_out = c;
  end

endmodule

// File: rtl/psc_trigger_packet_tx.sv
// PSC trigger packet sequencer: walks the ROM, streams bytes with K-flags,
// substitutes the computed CRC8 and enforces an inter-packet gap.
module psc_trigger_packet_tx
  import psc_trigger_pkg::*;
#(
  parameter logic [7:0]  CRC_POLY   = CRC_POLY_DEFAULT,
  parameter logic [7:0]  CRC_INIT   = 8'h00,
  parameter int unsigned GAP_CYCLES = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     start,
  input  logic                     trigger_state,
  output logic [3:0]               rom_address,
  output logic                     rom_is_trigger_state,
  input  logic [7:0]               rom_data,
  psc_trigger_packet_tx_if.master  tx,
  output logic                     busy,
  output logic                     done
);

  localparam int               GAP_W    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_CYCLES - 1);

  state_e           state_q, state_d;
  logic [3:0]       idx_q, idx_d;
  logic [7:0]       crc_q, crc_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic             trig_q, trig_d;
  logic             pend_q, pend_d;
  logic             pend_trig_q, pend_trig_d;
  logic             done_q, done_d;
  logic [7:0]       crc_next;

  // Only payload bytes reach the CRC, and for those tx_data is rom_data.
  psc_crc8 #(.CRC_POLY(CRC_POLY)) u_crc (
    .crc_in  (crc_q),
    .data_in (rom_data),
    .crc_out (crc_next)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      idx_q       <= IDX_SOP;
      crc_q       <= CRC_INIT;
      gap_q       <= '0;
      trig_q      <= 1'b0;
      pend_q      <= 1'b0;
      pend_trig_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      crc_q       <= crc_d;
      gap_q       <= gap_d;
      trig_q      <= trig_d;
      pend_q      <= pend_d;
      pend_trig_q <= pend_trig_d;
      done_q      <= done_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    crc_d       = crc_q;
    gap_d       = gap_q;
    trig_d      = trig_q;
    pend_d      = pend_q;
    pend_trig_d = pend_trig_q;
    done_d      = 1'b0;
    tx.tx_valid = 1'b0;
    tx.tx_k     = 1'b0;
    tx.tx_data  = 8'h00;
    rom_address = 4'd0;

    // One-deep request queue; the first request seen while busy wins.
    if ((state_q != ST_IDLE) && start && !pend_q) begin
      pend_d      = 1'b1;
      pend_trig_d = trigger_state;
    end

    case (state_q)
      ST_IDLE: begin
        if (start || pend_q) begin
          state_d = ST_SEND;
          idx_d   = IDX_SOP;
          crc_d   = CRC_INIT;
          trig_d  = pend_q ? pend_trig_q : trigger_state;
          pend_d  = 1'b0;
        end
      end

      ST_SEND: begin
        tx.tx_valid = 1'b1;
        rom_address = idx_q;
        tx.tx_data  = (idx_q == IDX_CRC) ? crc_q : rom_data;
        tx.tx_k     = (idx_q == IDX_SOP) || (idx_q == IDX_EOP);
        if (tx.tx_ready) begin
          if ((idx_q >= IDX_STATUS) && (idx_q < IDX_CRC)) begin
            crc_d = crc_next;
          end
          if (idx_q == IDX_EOP) begin
            state_d = ST_GAP;
            gap_d   = GAP_LOAD;
            idx_d   = IDX_SOP;
            done_d  = 1'b1;
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end
      end

      ST_GAP: begin
        if (gap_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          gap_d = gap_q - 1'b1;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  assign busy                 = (state_q != ST_IDLE);
  assign done                 = done_q;
  assign rom_is_trigger_state = trig_q;

endmodule

// File: tb/tb_psc_trigger_packet_tx.sv
// Directed bench for psc_trigger_packet_tx with a behavioural trigger ROM.
module tb_psc_trigger_packet_tx;

  logic       clk;
  logic       reset_n;
  logic       start, trigger_state;
  logic [3:0] rom_address;
  logic       rom_is_trigger_state;
  logic [7:0] rom_data;
  logic       busy, done;

  logic       start1, ts1;
  logic [3:0] rom_address1;
  logic       rom_trig1;
  logic [7:0] rom_data1;
  logic       busy1, done1;

  int errors = 0;
  int checks = 0;

  logic [7:0] TRIG_EXP [10] = '{8'h3C, 8'h01, 8'h30, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h7A, 8'hBC};
  logic [7:0] IDLE_EXP [10] = '{8'h3C, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'hBC};

  logic [7:0] rx_d [10];
  logic [3:0] rx_a [10];
  logic [9:0] rx_k;
  int         rx_n, rx_cyc, rx_held_bad;
  bit         rx_timeout, rx_trig_all, rx_trig_any;

  psc_trigger_packet_tx_if tx_if ();
  psc_trigger_packet_tx_if tx1_if ();

  psc_trigger_packet_tx #(.GAP_CYCLES(4)) dut (
    .clk                  (clk),
    .reset_n              (reset_n),
    .start                (start),
    .trigger_state        (trigger_state),
    .rom_address          (rom_address),
    .rom_is_trigger_state (rom_is_trigger_state),
    .rom_data             (rom_data),
    .tx                   (tx_if),
    .busy                 (busy),
    .done                 (done)
  );

  psc_trigger_packet_tx #(.GAP_CYCLES(1)) dut1 (
    .clk                  (clk),
    .reset_n              (reset_n),
    .start                (start1),
    .trigger_state        (ts1),
    .rom_address          (rom_address1),
    .rom_is_trigger_state (rom_trig1),
    .rom_data             (rom_data1),
    .tx                   (tx1_if),
    .busy                 (busy1),
    .done                 (done1)
  );

  function automatic logic [7:0] rom_byte(input logic trig, input logic [3:0] a);
    case (a)
      4'd0:    rom_byte = 8'h3C;
      4'd1:    rom_byte = trig ? 8'h01 : 8'h00;
      4'd2:    rom_byte = trig ? 8'h30 : 8'h00;
      4'd8:    rom_byte = 8'hFF;
      4'd9:    rom_byte = 8'hBC;
      default: rom_byte = 8'h00;
    endcase
  endfunction

  always_comb rom_data  = rom_byte(rom_is_trigger_state, rom_address);
  always_comb rom_data1 = rom_byte(rom_trig1, rom_address1);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Collects one packet, optionally stalling at two byte indices and
  // pulsing start once after pn bytes have been accepted.
  task automatic recv_packet(input int sa, input int sla, input int sb, input int slb,
                             input int pn, input logic pts);
    int left_a, left_b;
    bit pulsed, vld, rdy;
    logic [7:0] hd;
    logic [3:0] ha;
    left_a = sla; left_b = slb; pulsed = 0;
    rx_n = 0; rx_cyc = 0; rx_held_bad = 0; rx_timeout = 0;
    rx_trig_all = 1; rx_trig_any = 0; rx_k = '0;
    while (rx_n < 10) begin
      if (rx_cyc > 100) begin
        rx_timeout = 1;
        break;
      end
      vld = tx_if.tx_valid;
      rdy = 1;
      if (vld && int'(rom_address) == sa && left_a > 0) begin
        rdy = 0; left_a--;
      end else if (vld && int'(rom_address) == sb && left_b > 0) begin
        rdy = 0; left_b--;
      end
      tx_if.tx_ready = rdy;
      if (pn >= 0 && rx_n == pn && !pulsed) begin
        start = 1'b1; trigger_state = pts; pulsed = 1;
      end else begin
        start = 1'b0;
      end
      if (vld) begin
        rx_trig_all = rx_trig_all & rom_is_trigger_state;
        rx_trig_any = rx_trig_any | rom_is_trigger_state;
      end
      hd = tx_if.tx_data;
      ha = rom_address;
      if (vld && rdy) begin
        rx_d[rx_n] = hd;
        rx_a[rx_n] = ha;
        rx_k[rx_n] = tx_if.tx_k;
        rx_n++;
      end
      step();
      if (vld && !rdy && (tx_if.tx_data !== hd || rom_address !== ha)) rx_held_bad++;
      rx_cyc++;
    end
    start = 1'b0;
    tx_if.tx_ready = 1'b1;
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    start = 1'b0; trigger_state = 1'b0; tx_if.tx_ready = 1'b1;
    start1 = 1'b0; ts1 = 1'b0; tx1_if.tx_ready = 1'b1;
    step(); step();
    checks++;
    if ({tx_if.tx_valid, tx_if.tx_k, tx_if.tx_data, rom_address, rom_is_trigger_state, busy, done} !== 17'h0) begin
      errors++;
      $display("FAIL reset_outputs: got valid=%b k=%b data=%h addr=%h trig=%b busy=%b done=%b, want all zero",
               tx_if.tx_valid, tx_if.tx_k, tx_if.tx_data, rom_address, rom_is_trigger_state, busy, done);
    end
    reset_n = 1'b1;
    step();
    checks++;
    if (busy !== 1'b0 || tx_if.tx_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_release_idle: got busy=%b valid=%b, want 0 0", busy, tx_if.tx_valid);
    end
  endtask

  task automatic test_trigger_packet;
    start = 1'b1; trigger_state = 1'b1;
    step();
    start = 1'b0; trigger_state = 1'b0;
    checks++;
    if (tx_if.tx_valid !== 1'b1 || tx_if.tx_data !== 8'h3C || tx_if.tx_k !== 1'b1) begin
      errors++;
      $display("FAIL trig_latency: got valid=%b data=%h k=%b, want 1 3c 1", tx_if.tx_valid, tx_if.tx_data, tx_if.tx_k);
    end
    recv_packet(-1, 0, -1, 0, -1, 1'b0);
    checks++;
    if (rx_timeout) begin
      errors++;
      $display("FAIL trig_timeout: got %0d bytes, want 10", rx_n);
    end
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (rx_d[i] !== TRIG_EXP[i] || rx_a[i] !== 4'(i)) begin
        errors++;
        $display("FAIL trig_byte%0d: got data=%h addr=%h, want %h %h", i, rx_d[i], rx_a[i], TRIG_EXP[i], i);
      end
    end
    checks++;
    if (rx_k !== 10'b10_0000_0001) begin
      errors++;
      $display("FAIL trig_kflags: got %b, want 1000000001", rx_k);
    end
    checks++;
    if (rx_trig_all !== 1'b1) begin
      errors++;
      $display("FAIL trig_rom_state: got all=%b, want 1", rx_trig_all);
    end
    checks++;
    if (done !== 1'b1 || busy !== 1'b1 || tx_if.tx_valid !== 1'b0) begin
      errors++;
      $display("FAIL trig_done_pulse: got done=%b busy=%b valid=%b, want 1 1 0", done, busy, tx_if.tx_valid);
    end
    step();
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL trig_done_width: got %b, want 0", done);
    end
    step(); step();
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL trig_gap_last: got busy=%b, want 1", busy);
    end
    step();
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL trig_gap_end: got busy=%b, want 0", busy);
    end
  endtask

  task automatic test_idle_packet;
    start = 1'b1; trigger_state = 1'b0;
    step();
    start = 1'b0;
    recv_packet(-1, 0, -1, 0, -1, 1'b0);
    checks++;
    if (rx_timeout) begin
      errors++;
      $display("FAIL idle_timeout: got %0d bytes, want 10", rx_n);
    end
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (rx_d[i] !== IDLE_EXP[i]) begin
        errors++;
        $display("FAIL idle_byte%0d: got %h, want %h", i, rx_d[i], IDLE_EXP[i]);
      end
    end
    checks++;
    if (rx_trig_any !== 1'b0) begin
      errors++;
      $display("FAIL idle_rom_state: got any=%b, want 0", rx_trig_any);
    end
    repeat (4) step();
  endtask

  task automatic test_backpressure;
    start = 1'b1; trigger_state = 1'b1;
    step();
    start = 1'b0;
    recv_packet(2, 3, 8, 2, -1, 1'b0);
    checks++;
    if (rx_timeout || rx_cyc != 15) begin
      errors++;
      $display("FAIL bp_cycles: got %0d cycles (timeout=%b), want 15", rx_cyc, rx_timeout);
    end
    checks++;
    if (rx_held_bad != 0) begin
      errors++;
      $display("FAIL bp_hold: got %0d changed stall cycles, want 0", rx_held_bad);
    end
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (rx_d[i] !== TRIG_EXP[i]) begin
        errors++;
        $display("FAIL bp_byte%0d: got %h, want %h", i, rx_d[i], TRIG_EXP[i]);
      end
    end
    repeat (4) step();
  endtask

  task automatic test_back_to_back;
    start = 1'b1; trigger_state = 1'b1;
    step();
    start = 1'b0;
    recv_packet(-1, 0, -1, 0, 3, 1'b0);
    start = 1'b1; trigger_state = 1'b1;
    step();
    start = 1'b0;
    step(); step();
    checks++;
    if (busy !== 1'b1 || tx_if.tx_valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_gap4: got busy=%b valid=%b, want 1 0", busy, tx_if.tx_valid);
    end
    step();
    checks++;
    if (busy !== 1'b0 || tx_if.tx_valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_idle: got busy=%b valid=%b, want 0 0", busy, tx_if.tx_valid);
    end
    step();
    checks++;
    if (tx_if.tx_valid !== 1'b1 || tx_if.tx_data !== 8'h3C || rom_is_trigger_state !== 1'b0) begin
      errors++;
      $display("FAIL b2b_second_sop: got valid=%b data=%h trig=%b, want 1 3c 0",
               tx_if.tx_valid, tx_if.tx_data, rom_is_trigger_state);
    end
    recv_packet(-1, 0, -1, 0, -1, 1'b0);
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (rx_d[i] !== IDLE_EXP[i]) begin
        errors++;
        $display("FAIL b2b_byte%0d: got %h, want %h", i, rx_d[i], IDLE_EXP[i]);
      end
    end
    repeat (7) step();
    checks++;
    if (busy !== 1'b0 || tx_if.tx_valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_no_third: got busy=%b valid=%b, want 0 0", busy, tx_if.tx_valid);
    end
  endtask

  task automatic test_reset_midpacket;
    start = 1'b1; trigger_state = 1'b1;
    step();
    start = 1'b0;
    repeat (5) step();
    checks++;
    if (rom_address !== 4'd5 || tx_if.tx_valid !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid_pos: got addr=%h valid=%b, want 5 1", rom_address, tx_if.tx_valid);
    end
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (tx_if.tx_valid !== 1'b0 || busy !== 1'b0 || rom_address !== 4'd0 || rom_is_trigger_state !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_async: got valid=%b busy=%b addr=%h trig=%b, want 0 0 0 0",
               tx_if.tx_valid, busy, rom_address, rom_is_trigger_state);
    end
    step();
    reset_n = 1'b1;
    step();
    start = 1'b1; trigger_state = 1'b1;
    step();
    start = 1'b0;
    recv_packet(-1, 0, -1, 0, -1, 1'b0);
    checks++;
    if (rx_timeout) begin
      errors++;
      $display("FAIL rst_mid_timeout: got %0d bytes, want 10", rx_n);
    end
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (rx_d[i] !== TRIG_EXP[i]) begin
        errors++;
        $display("FAIL rst_mid_byte%0d: got %h, want %h", i, rx_d[i], TRIG_EXP[i]);
      end
    end
    repeat (4) step();
  endtask

  task automatic test_gap_one;
    logic [2:0] exp;
    start1 = 1'b1; ts1 = 1'b1;
    for (int c = 0; c < 36; c++) begin
      step();
      exp = (c % 12 < 10) ? 3'b110 : ((c % 12 == 10) ? 3'b011 : 3'b000);
      checks++;
      if ({tx1_if.tx_valid, busy1, done1} !== exp) begin
        errors++;
        $display("FAIL gap1_cycle%0d: got valid/busy/done=%b, want %b", c, {tx1_if.tx_valid, busy1, done1}, exp);
      end
      if (c % 12 == 8) begin
        checks++;
        if (tx1_if.tx_data !== 8'h7A) begin
          errors++;
          $display("FAIL gap1_crc%0d: got %h, want 7a", c, tx1_if.tx_data);
        end
      end
    end
    start1 = 1'b0;
  endtask

  initial begin
    test_reset();
    test_trigger_packet();
    test_idle_packet();
    test_backpressure();
    test_back_to_back();
    test_reset_midpacket();
    test_gap_one();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
